// File: rtl/datamemory_pkg.sv
// Shared types and address-split helpers for the byte-lane data memory.
package datamemory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int BYTE_BITS = 8;
    localparam int DEF_ADDRESSWIDTH = 8;
    localparam int DEF_WIDTH = 16;

    function automatic int lanes_of(input int w);
        return w / BYTE_BITS;
    endfunction

    // Number of low address bits needed to select one of the byte lanes.
    function automatic int lanebits_of(input int w);
        int b;
        b = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << b) < lanes_of(w)) begin
                b = b + 1;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/datamemory_ram.sv
// Byte-lane synchronous RAM; registered read returns the merged post-write word.
module datamemory_ram #(
    parameter int width = 16,
    parameter int lanes = 2,
    parameter int idxw  = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [lanes-1:0] byteEnable,
    input  logic [idxw-1:0]  index,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [2**idxw];
    logic [width-1:0] merged;

    always_comb begin
        merged = mem[index];
        for (int i = 0; i < lanes; i++) begin
            if (we && byteEnable[i]) begin
                merged[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= merged;
        end
        rdata <= merged;
    end

endmodule

// File: rtl/datamemory_ctrl.sv
// Data memory controller: post-reset clear, alignment check and 1-cycle responses.
module datamemory_ctrl
    import datamemory_pkg::*;
#(
    parameter int addresswidth = DEF_ADDRESSWIDTH,
    parameter int width        = DEF_WIDTH,
    parameter int align_check  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [addresswidth-1:0]  addressr,
    input  logic [width-1:0]         dataIn,
    input  logic [lanes_of(width)-1:0] byteEnable,
    output logic                     rsp_valid,
    output logic [width-1:0]         dataOut,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int lanes    = lanes_of(width);
    localparam int lanebits = lanebits_of(width);
    localparam int idxw     = addresswidth - lanebits;

    state_t state, state_n;
    logic [idxw-1:0]  cnt, cnt_n;
    logic             misaligned;
    logic             accept;
    logic             ram_we;
    logic [lanes-1:0] ram_be;
    logic [idxw-1:0]  ram_idx;
    logic [width-1:0] ram_wdata;
    logic [width-1:0] ram_rdata;
    logic [width-1:0] hold;

    generate
        if (align_check != 0 && lanebits > 0) begin : g_align
            assign misaligned = |addressr[lanebits-1:0];
        end else begin : g_noalign
            assign misaligned = 1'b0;
        end
    endgenerate

    assign req_ready = (state == IDLE);
    assign busy      = (state == CLEAR);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ram_we    = 1'b0;
        ram_be    = byteEnable;
        ram_idx   = addressr[addresswidth-1:lanebits];
        ram_wdata = dataIn;
        unique case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_be    = '1;
                ram_idx   = cnt;
                ram_wdata = '0;
                cnt_n     = cnt + idxw'(1);
                if (cnt == {idxw{1'b1}}) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                // A reset arriving with a request must not disturb memory.
                ram_we = accept & req_write & ~misaligned & ~reset;
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            hold      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rsp_valid <= accept;
            if (accept) begin
                rsp_err <= misaligned;
            end
            if (rsp_valid && !rsp_err) begin
                hold <= ram_rdata;
            end
        end
    end

    // Misaligned or idle cycles show the last good word, not the RAM port.
    assign dataOut = (rsp_valid && !rsp_err) ? ram_rdata : hold;

    datamemory_ram #(
        .width(width),
        .lanes(lanes),
        .idxw (idxw)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .byteEnable(ram_be),
        .index     (ram_idx),
        .wdata     (ram_wdata),
        .rdata     (ram_rdata)
    );

endmodule

// File: tb/tb_datamemory_ctrl.sv
// Bench for datamemory_ctrl: directed plan plus random traffic against a word-array model.
module tb_datamemory_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [7:0]  addressr;
    logic [15:0] dataIn;
    logic [1:0]  byteEnable;

    logic        r0_ready, r0_valid, r0_err, r0_busy;
    logic [15:0] r0_data;
    logic        r1_ready, r1_valid, r1_err, r1_busy;
    logic [15:0] r1_data;

    int checks = 0;
    int failures = 0;

    logic [15:0] m0 [128];
    logic [15:0] m1 [128];
    logic [15:0] last0, last1;
    logic        err0;

    always #5 clk = ~clk;

    datamemory_ctrl #(.addresswidth(8), .width(16), .align_check(1)) d0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r0_ready),
        .req_write(req_write), .addressr(addressr), .dataIn(dataIn),
        .byteEnable(byteEnable), .rsp_valid(r0_valid), .dataOut(r0_data),
        .rsp_err(r0_err), .busy(r0_busy)
    );

    datamemory_ctrl #(.addresswidth(8), .width(16), .align_check(0)) d1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r1_ready),
        .req_write(req_write), .addressr(addressr), .dataIn(dataIn),
        .byteEnable(byteEnable), .rsp_valid(r1_valid), .dataOut(r1_data),
        .rsp_err(r1_err), .busy(r1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0] = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 128; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        last0 = '0;
        last1 = '0;
        err0  = 1'b0;
    endtask

    // One request accepted at the next posedge; response checked right after it.
    task automatic req(input bit w, input logic [7:0] a, input logic [15:0] d,
                       input logic [1:0] be);
        int idx;
        @(negedge clk);
        chk("ready", {r0_ready, r1_ready}, 2'b11);
        req_valid  = 1'b1;
        req_write  = w;
        addressr   = a;
        dataIn     = d;
        byteEnable = be;
        idx = a / 2;
        if (a % 2 != 0) begin
            err0 = 1'b1;
        end else begin
            err0 = 1'b0;
            if (w) m0[idx] = merge(m0[idx], d, be);
            last0 = m0[idx];
        end
        if (w) m1[idx] = merge(m1[idx], d, be);
        last1 = m1[idx];
        @(posedge clk);
        #1;
        chk("rsp_valid", {r0_valid, r1_valid}, 2'b11);
        chk("rsp_err0", r0_err, err0);
        chk("rsp_err1", r1_err, 1'b0);
        chk("data0", r0_data, last0);
        chk("data1", r1_data, last1);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("no_rsp", {r0_valid, r1_valid}, 2'b00);
        chk("hold0", r0_data, last0);
        chk("hold1", r1_data, last1);
    endtask

    // Called just after reset is released at a negedge.
    task automatic wait_clear();
        int n;
        n = 0;
        model_clear();
        do begin
            @(posedge clk);
            #1;
            n++;
            if (r0_busy) begin
                chk("clr_ready", {r0_ready, r1_ready}, 2'b00);
                chk("clr_rsp", {r0_valid, r1_valid}, 2'b00);
            end
        end while (r0_busy && n < 1000);
        chk("clear_len", n, 128);
        chk("clear_done", {r0_busy, r1_busy, r0_ready, r1_ready}, 4'b0011);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        addressr   = '0;
        dataIn     = '0;
        byteEnable = '0;
        model_clear();

        @(posedge clk);
        #1;
        chk("rst_busy", {r0_busy, r1_busy}, 2'b11);
        chk("rst_ready", {r0_ready, r1_ready}, 2'b00);
        chk("rst_rsp", {r0_valid, r0_err, r1_valid, r1_err}, 4'b0000);
        chk("rst_data", {r0_data, r1_data}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_clear();

        req(0, 8'hFE, 16'h0, 2'b00);
        req(1, 8'h10, 16'hBEEF, 2'b11);
        req(0, 8'h10, 16'h0, 2'b00);
        req(1, 8'h10, 16'h1234, 2'b01);
        chk("be01", r0_data, 16'hBE34);
        req(0, 8'h10, 16'h0, 2'b00);
        req(1, 8'h11, 16'h5555, 2'b11);
        chk("mis_hold", r0_data, 16'hBE34);
        req(0, 8'h10, 16'h0, 2'b00);
        chk("noalign_w8", r1_data, 16'h5555);
        req(1, 8'h10, 16'hAAAA, 2'b00);
        idle();

        for (int i = 0; i < 80; i++) begin
            req($urandom_range(0, 1), 8'($urandom_range(0, 31)),
                16'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        // Reset in the middle of a clear restarts the full sequence.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_clear();
        req(0, 8'h10, 16'h0, 2'b00);
        req(1, 8'h20, 16'hC0DE, 2'b11);
        idle();

        // Reset sampled together with a read accept drops the response.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        addressr  = 8'h20;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drop", {r0_valid, r1_valid}, 2'b00);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        wait_clear();
        req(0, 8'h20, 16'h0, 2'b00);
        idle();

        // Request held through CLEAR is taken on the first ready cycle.
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        addressr  = 8'h20;
        @(negedge clk);
        reset = 1'b0;
        wait_clear();
        @(posedge clk);
        #1;
        chk("first_acc", {r0_valid, r1_valid, r0_err}, 3'b110);
        chk("first_data", r0_data, 16'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
